motor_seg_sched: RTL

//  Segment scheduler between the host register bus and motor_cont. Queues segment records
//  (per-motor N, T, motor mask, task_id) in a DEPTH-entry FIFO. Issues each record to

---
 rtl/motor_seg_pkg.sv | 24 ++
 rtl/motor_seg_sched_if.sv | 43 ++++
 rtl/seg_fifo.sv | 70 +++++++
 rtl/motor_seg_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/motor_seg_pkg.sv
// Shared types for the motor segment scheduler: FSM states and the queued segment record.
package motor_seg_pkg;

    // Widest motor count the record layout supports; narrower builds leave upper lanes zero.
    localparam int MOTORS_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        SETTLE
    } state_t;

    // One queued segment: which motors it loads, their step counts and periods,
    // the task it belongs to, and whether it closes the motion stream.
    typedef struct packed {
        logic [MOTORS_MAX-1:0]         mask;
        logic [MOTORS_MAX-1:0][31:0]   n;
        logic [MOTORS_MAX-1:0][31:0]   t;
        logic [31:0]                   id;
        logic                          last;
    } seg_t;

endpackage

// File: rtl/motor_seg_sched_if.sv
// Host-side queue port plus the motor_cont handshake, bundled for the scheduler.
interface motor_seg_sched_if #(
    parameter int MOTORS = 4,
    parameter int DEPTH  = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                   push;
    logic [MOTORS-1:0]      push_mask;
    logic [MOTORS*32-1:0]   push_N;
    logic [MOTORS*32-1:0]   push_T;
    logic [31:0]            push_id;
    logic                   push_last;
    logic                   abort;
    logic                   clr_flags;
    logic [MOTORS-1:0]      wrreq;
    logic [MOTORS-1:0]      run;

    logic [MOTORS*32-1:0]   N;
    logic [MOTORS*32-1:0]   T;
    logic [31:0]            task_id;
    logic [MOTORS-1:0]      write;
    logic [LW-1:0]          level;
    logic                   full;
    logic                   busy;
    logic                   overflow;
    logic                   underrun;

    // Host and motor_cont side together: drives records, wrreq and run; observes the rest.
    modport master (
        output push, push_mask, push_N, push_T, push_id, push_last,
        output abort, clr_flags, wrreq, run,
        input  N, T, task_id, write, level, full, busy, overflow, underrun
    );

    // The scheduler itself.
    modport slave (
        input  push, push_mask, push_N, push_T, push_id, push_last,
        input  abort, clr_flags, wrreq, run,
        output N, T, task_id, write, level, full, busy, overflow, underrun
    );

endinterface

// File: rtl/seg_fifo.sv
// Register FIFO of segment records. Full is taken from the registered count, so a pop
// in the same cycle never makes room for a push. Flush empties the queue at the next edge.
module seg_fifo
    import motor_seg_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic                    sclr,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  seg_t                    din,
    output seg_t                    head,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [LW-1:0]  count_q;
    seg_t           mem_q [DEPTH];
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_q == LW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign head    = mem_q[rd_ptr_q];
    assign level   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (sclr || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Record storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/motor_seg_sched.sv
// Segment scheduler: queues host records and hands each one to motor_cont once every
// motor it targets is ready, then flags overflow and motion underrun for the host.
module motor_seg_sched
    import motor_seg_pkg::*;
#(
    parameter int MOTORS = 4,
    parameter int DEPTH  = 8
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                sclr,
    motor_seg_sched_if.slave    bus
);

    localparam int LW = $clog2(DEPTH) + 1;

    seg_t                       push_rec;
    seg_t                       head;
    logic [LW-1:0]              level;
    logic                       full;
    logic                       empty;
    logic                       pop;
    logic                       load_en;
    logic                       issue_ok;
    logic [MOTORS_MAX-1:0]      wrreq_ext;
    logic [MOTORS-1:0]          write_d;
    state_t                     state_q;
    state_t                     state_d;
    logic [MOTORS-1:0][31:0]    n_q;
    logic [MOTORS-1:0][31:0]    t_q;
    logic [31:0]                id_q;
    logic                       end_seen_q;
    logic                       run_any_q;
    logic                       overflow_q;
    logic                       underrun_q;
    logic                       run_fall;
    logic                       overflow_set;
    logic                       underrun_set;

    // Pack the flat host buses into a record; lanes above MOTORS stay zero.
    always_comb begin
        push_rec = '0;
        for (int k = 0; k < MOTORS; k++) begin
            push_rec.mask[k] = bus.push_mask[k];
            push_rec.n[k]    = bus.push_N[32*k +: 32];
            push_rec.t[k]    = bus.push_T[32*k +: 32];
        end
        push_rec.id   = bus.push_id;
        push_rec.last = bus.push_last;
    end

    seg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .aclr  (aclr),
        .sclr  (sclr),
        .push  (bus.push && !bus.abort),
        .pop   (pop),
        .flush (bus.abort),
        .din   (push_rec),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Widen wrreq to the record mask width so the readiness compare covers every mask bit.
    always_comb begin
        wrreq_ext = '0;
        for (int k = 0; k < MOTORS; k++) begin
            wrreq_ext[k] = bus.wrreq[k];
        end
    end

    assign issue_ok = ((wrreq_ext & head.mask) == head.mask);

    // FSM state register.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
        end else if (sclr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: wait for a head record whose motors are all ready, then walk the issue sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty && issue_ok) state_d = LOAD;
            LOAD:    state_d = ISSUE;
            ISSUE:   state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort) begin
            state_d = IDLE;
        end
    end

    // FSM outputs: load strobe in LOAD, write strobe and pop in ISSUE, all killed by abort.
    always_comb begin
        write_d = '0;
        pop     = 1'b0;
        load_en = 1'b0;
        if (!bus.abort) begin
            case (state_q)
                LOAD:  load_en = 1'b1;
                ISSUE: begin
                    pop = 1'b1;
                    for (int k = 0; k < MOTORS; k++) begin
                        write_d[k] = head.mask[k];
                    end
                end
                default: ;
            endcase
        end
    end

    // Segment data registers: only masked lanes take new N/T, task id always follows the record.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            n_q  <= '0;
            t_q  <= '1;
            id_q <= '0;
        end else if (sclr) begin
            n_q  <= '0;
            t_q  <= '1;
            id_q <= '0;
        end else if (load_en) begin
            for (int k = 0; k < MOTORS; k++) begin
                if (head.mask[k]) begin
                    n_q[k] <= head.n[k];
                    t_q[k] <= head.t[k];
                end
            end
            id_q <= head.id;
        end
    end

    // Remember whether the last issued record closed the stream; abort counts as a clean end.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            end_seen_q <= 1'b1;
        end else if (sclr || bus.abort) begin
            end_seen_q <= 1'b1;
        end else if (state_q == ISSUE) begin
            end_seen_q <= head.last;
        end
    end

    // Previous-cycle activity of any motor, for detecting the moment they all stop.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            run_any_q <= 1'b0;
        end else if (sclr) begin
            run_any_q <= 1'b0;
        end else begin
            run_any_q <= |bus.run;
        end
    end

    assign run_fall     = run_any_q && !(|bus.run);
    assign underrun_set = run_fall && empty && (state_q == IDLE) && !end_seen_q;
    assign overflow_set = bus.push && full && !bus.abort;

    // Sticky flags; a new event wins over a host clear in the same cycle.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else if (sclr) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_flags) begin
                overflow_q <= 1'b0;
            end
            if (underrun_set) begin
                underrun_q <= 1'b1;
            end else if (bus.clr_flags) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign bus.N        = n_q;
    assign bus.T        = t_q;
    assign bus.task_id  = id_q;
    assign bus.write    = write_d;
    assign bus.level    = level;
    assign bus.full     = full;
    assign bus.busy     = (state_q != IDLE) || !empty;
    assign bus.overflow = overflow_q;
    assign bus.underrun = underrun_q;

endmodule
